seven_segment_cntrl: RTL and testbench

SEVEN_SEGMENT_CNTRL -- requirements
Module: seven_segment_cntrl

---
 rtl/seven_segment_cntrl_pkg.sv | 18 +
 rtl/seven_segment_cntrl_seg7_decode.sv | 24 ++
 rtl/seven_segment_cntrl.sv | 55 +++++
 tb/tb_seven_segment_cntrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/seven_segment_cntrl_pkg.sv
// rtl/seven_segment_cntrl_pkg.sv - shared seven-segment pattern constants
// Patterns are logical {a,b,c,d,e,f,g}, 1 = segment lit.
package seven_segment_cntrl_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0       = 7'b1111110;
    localparam seg_t SEG_1       = 7'b0110000;
    localparam seg_t SEG_2       = 7'b1101101;
    localparam seg_t SEG_3       = 7'b1111001;
    localparam seg_t SEG_4       = 7'b0110011;
    localparam seg_t SEG_5       = 7'b1011011;
    localparam seg_t SEG_6       = 7'b1011111;
    localparam seg_t SEG_7       = 7'b1110000;
    localparam seg_t SEG_ALL_ON  = 7'b1111111;
    localparam seg_t SEG_ALL_OFF = 7'b0000000;

endpackage

// File: rtl/seven_segment_cntrl_seg7_decode.sv
// rtl/seven_segment_cntrl_seg7_decode.sv - 3-bit digit to logical segment pattern
// Purely combinational; every code maps to a digit.
module seg7_decode
    import seven_segment_cntrl_pkg::*;
(
    input  logic [2:0] digit_i,
    output seg_t       pattern_o
);

    always_comb begin
        pattern_o = SEG_ALL_OFF;
        case (digit_i)
            3'd0: pattern_o = SEG_0;
            3'd1: pattern_o = SEG_1;
            3'd2: pattern_o = SEG_2;
            3'd3: pattern_o = SEG_3;
            3'd4: pattern_o = SEG_4;
            3'd5: pattern_o = SEG_5;
            3'd6: pattern_o = SEG_6;
            3'd7: pattern_o = SEG_7;
        endcase
    end

endmodule

// File: rtl/seven_segment_cntrl.sv
// rtl/seven_segment_cntrl.sv - registered seven-segment driver with blank and lamp test
// Priority rst > lamp_test > blank > decode; one clock of latency, outputs straight from flops.
module seven_segment_cntrl
    import seven_segment_cntrl_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] inp,
    input  logic       blank,
    input  logic       lamp_test,
    output logic       seg_a,
    output logic       seg_b,
    output logic       seg_c,
    output logic       seg_d,
    output logic       seg_e,
    output logic       seg_f,
    output logic       seg_g
);

    localparam seg_t POL_MASK = {7{ACTIVE_LOW}};

    seg_t decoded;
    seg_t logical;
    seg_t seg_d_n;
    seg_t seg_q;

    seg7_decode u_decode (
        .digit_i   (inp),
        .pattern_o (decoded)
    );

    always_comb begin
        logical = decoded;
        if (lamp_test) begin
            logical = SEG_ALL_ON;
        end else if (blank) begin
            logical = SEG_ALL_OFF;
        end
        seg_d_n = logical ^ POL_MASK;
    end

    // Reset value is "dark" after polarity, so common-anode parts idle at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_ALL_OFF ^ POL_MASK;
        end else begin
            seg_q <= seg_d_n;
        end
    end

    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_q;

endmodule

// File: tb/tb_seven_segment_cntrl.sv
// tb/tb_seven_segment_cntrl.sv - self-checking bench for both output polarities
module tb_seven_segment_cntrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] inp = 3'd0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;

    logic [6:0] out_hi;
    logic [6:0] out_lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] digit_tbl [8] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};

    logic [6:0] model_q;
    bit         model_valid = 1'b0;

    always #5 clk = ~clk;

    seven_segment_cntrl #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .inp(inp), .blank(blank), .lamp_test(lamp_test),
        .seg_a(out_hi[6]), .seg_b(out_hi[5]), .seg_c(out_hi[4]), .seg_d(out_hi[3]),
        .seg_e(out_hi[2]), .seg_f(out_hi[1]), .seg_g(out_hi[0])
    );

    seven_segment_cntrl #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst(rst), .inp(inp), .blank(blank), .lamp_test(lamp_test),
        .seg_a(out_lo[6]), .seg_b(out_lo[5]), .seg_c(out_lo[4]), .seg_d(out_lo[3]),
        .seg_e(out_lo[2]), .seg_f(out_lo[1]), .seg_g(out_lo[0])
    );

    function automatic logic [6:0] expected_logical(bit r, bit lt, bit bl, int unsigned d);
        if (r)  return 7'b0000000;
        if (lt) return 7'b1111111;
        if (bl) return 7'b0000000;
        return digit_tbl[d];
    endfunction

    task automatic check(string name, logic [6:0] act, logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        model_q     <= expected_logical(rst, lamp_test, blank, inp);
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_hi", out_hi, model_q);
            check("model_lo", out_lo, ~model_q);
        end
    end

    task automatic apply(bit r, bit lt, bit bl, logic [2:0] d, logic [6:0] exp, string name);
        @(negedge clk);
        rst = r; lamp_test = lt; blank = bl; inp = d;
        @(posedge clk);
        #1;
        check({name, "_hi"}, out_hi, exp);
        check({name, "_lo"}, out_lo, ~exp);
    endtask

    initial begin
        logic [2:0] seq [8];
        logic [6:0] seq_exp [8];
        seq     = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd4, 3'd7};
        seq_exp = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b1011011, 7'b1011111, 7'b0110011, 7'b1110000};

        apply(1'b1, 1'b0, 1'b0, 3'd0, 7'b0000000, "reset1");
        apply(1'b1, 1'b1, 1'b0, 3'd5, 7'b0000000, "reset2");

        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 1'b0, seq[i], seq_exp[i], $sformatf("digit%0d", seq[i]));
        end

        apply(1'b0, 1'b0, 1'b1, 3'd3, 7'b0000000, "blank");
        apply(1'b0, 1'b1, 1'b1, 3'd3, 7'b1111111, "lamp_over_blank");
        apply(1'b0, 1'b0, 1'b0, 3'd3, 7'b1111001, "release_3");

        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 1'b0, 3'(i), seq_exp[0] ^ seq_exp[0] | digit_tbl[i],
                  $sformatf("step%0d", i));
        end

        apply(1'b1, 1'b1, 1'b0, 3'd7, 7'b0000000, "rst_over_lamp");
        apply(1'b0, 1'b1, 1'b0, 3'd7, 7'b1111111, "rst_release_lamp");
        apply(1'b0, 1'b0, 1'b0, 3'd1, 7'b0110000, "digit1_pol");

        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 19) == 0);
            lamp_test = ($urandom_range(0, 7) == 0);
            blank     = ($urandom_range(0, 5) == 0);
            inp       = 3'($urandom_range(0, 7));
        end

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
